// File: rtl/sie_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sie_tx_pkg
// Description : Shared definitions for the SIE transmit packet sequencer:
//               port command codes, sequencer states, USB CRC16 constants
//               and a single-byte CRC16 update helper.
// Revision    : 1.0  initial release
// ============================================================================
package sie_tx_pkg;

  // Command code carried in SIEPortCtrlIn[1:0]
  typedef enum logic [1:0] {
    CMD_CLR_ERR = 2'd0,
    CMD_START   = 2'd1,
    CMD_DATA    = 2'd2,
    CMD_END     = 2'd3
  } sie_tx_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
    ST_EOP    = 3'd6
  } sie_tx_state_e;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  // Reflected CRC16 update over one byte, LSB first (USB bit order).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sie_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sie_tx_byte_fifo
// Description : Small byte FIFO holding queued transmit payload.
//               Push is ignored when full, pop is ignored when empty; a push
//               and a pop in the same cycle are both honoured.
// Ports       : clk, rst_n (sync, active-low), i_push/i_wdata, i_pop,
//               o_head (oldest entry), o_full, o_empty
// Revision    : 1.0  initial release
// ============================================================================
module sie_tx_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (count_q == c_full_cnt);
  assign o_empty   = (count_q == '0);
  assign o_head    = mem_q[rd_ptr_q];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(w_do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_do_pop);
    count_d  = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sie_port_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : sie_port_tx_seq
// Description : Transmit packet sequencer. Converts host/slave port writes
//               into the byte stream SYNC, PID, payload, optional CRC16,
//               followed by an EOP request to the serializer.
// Ports       : usbClk, rstSyncToUsbClk_n (sync, active-low)
//               SIEPortCtrlIn/DataIn/WEn, SIEPortTxRdy   - command port
//               txByte/txByteValid/txByteReady            - byte handshake
//               txEopReq/txEopAck                         - EOP handshake
//               txBusy, txOverflow, txProtoErr, txUnderrun - status
// Revision    : 1.0  initial release
// ============================================================================
module sie_port_tx_seq
  import sie_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'h80
) (
  input  logic       usbClk,
  input  logic       rstSyncToUsbClk_n,
  input  logic [7:0] SIEPortCtrlIn,
  input  logic [7:0] SIEPortDataIn,
  input  logic       SIEPortWEn,
  output logic       SIEPortTxRdy,
  output logic [7:0] txByte,
  output logic       txByteValid,
  input  logic       txByteReady,
  output logic       txEopReq,
  input  logic       txEopAck,
  output logic       txBusy,
  output logic       txOverflow,
  output logic       txProtoErr,
  output logic       txUnderrun
);

  sie_tx_state_e state_q, state_d;
  logic [7:0]    pid_q, pid_d;
  logic [15:0]   crc_q, crc_d;
  logic          end_pending_q, end_pending_d;
  logic          append_crc_q, append_crc_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          eop_req_q, eop_req_d;
  logic          ovf_q, ovf_d;
  logic          proto_q, proto_d;
  logic          unr_q, unr_d;

  sie_tx_cmd_e   w_cmd;
  logic          w_xfer;
  logic          w_idle;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_fifo_head;
  logic          w_set_ovf;
  logic          w_set_proto;
  logic          w_set_unr;
  logic          w_clr_err;
  logic          w_unused_ctrl;

  assign w_cmd         = sie_tx_cmd_e'(SIEPortCtrlIn[1:0]);
  assign w_unused_ctrl = ^SIEPortCtrlIn[7:3];
  assign w_xfer        = tx_valid_q && txByteReady;
  assign w_idle        = (state_q == ST_IDLE);

  sie_tx_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (usbClk),
    .rst_n   (rstSyncToUsbClk_n),
    .i_push  (w_fifo_push),
    .i_wdata (SIEPortDataIn),
    .i_pop   (w_fifo_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    crc_d         = crc_q;
    end_pending_d = end_pending_q;
    append_crc_d  = append_crc_q;
    tx_byte_d     = tx_byte_q;
    tx_valid_d    = tx_valid_q;
    eop_req_d     = eop_req_q;
    w_fifo_push   = 1'b0;
    w_fifo_pop    = 1'b0;
    w_set_ovf     = 1'b0;
    w_set_proto   = 1'b0;
    w_set_unr     = 1'b0;
    w_clr_err     = 1'b0;

    // Byte stream sequencing
    case (state_q)
      ST_IDLE: ;
      ST_SYNC: begin
        if (w_xfer) begin
          tx_byte_d = pid_q;
          state_d   = ST_PID;
        end
      end
      ST_PID: begin
        if (w_xfer) begin
          tx_valid_d = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_valid_q) begin
          // Presented byte is the FIFO head; it leaves the FIFO only once taken.
          if (w_xfer) begin
            w_fifo_pop = 1'b1;
            crc_d      = crc16_byte(crc_q, tx_byte_q);
            tx_valid_d = 1'b0;
          end
        end else if (!w_fifo_empty) begin
          tx_byte_d  = w_fifo_head;
          tx_valid_d = 1'b1;
        end else if (end_pending_q) begin
          if (append_crc_q) begin
            tx_byte_d  = ~crc_q[7:0];
            tx_valid_d = 1'b1;
            state_d    = ST_CRC_LO;
          end else begin
            eop_req_d = 1'b1;
            state_d   = ST_EOP;
          end
        end else if (txByteReady) begin
          w_set_unr = 1'b1;
        end
      end
      ST_CRC_LO: begin
        if (w_xfer) begin
          tx_byte_d = ~crc_q[15:8];
          state_d   = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (w_xfer) begin
          tx_valid_d = 1'b0;
          eop_req_d  = 1'b1;
          state_d    = ST_EOP;
        end
      end
      ST_EOP: begin
        if (txEopAck) begin
          eop_req_d     = 1'b0;
          end_pending_d = 1'b0;
          append_crc_d  = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Port command decode
    if (SIEPortWEn) begin
      case (w_cmd)
        CMD_CLR_ERR: w_clr_err = 1'b1;
        CMD_START: begin
          if (w_idle) begin
            pid_d      = SIEPortDataIn;
            crc_d      = CRC16_INIT;
            tx_byte_d  = SYNC_BYTE;
            tx_valid_d = 1'b1;
            state_d    = ST_SYNC;
          end else begin
            w_set_proto = 1'b1;
          end
        end
        CMD_DATA: begin
          if (w_idle || end_pending_q) begin
            w_set_proto = 1'b1;
          end else if (w_fifo_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_fifo_push = 1'b1;
          end
        end
        CMD_END: begin
          if (w_idle || end_pending_q) begin
            w_set_proto = 1'b1;
          end else begin
            end_pending_d = 1'b1;
            append_crc_d  = SIEPortCtrlIn[2];
          end
        end
        default: ;
      endcase
    end

    // A new error in the same cycle as CLR_ERR keeps its flag set.
    ovf_d   = w_set_ovf   | (ovf_q   & ~w_clr_err);
    proto_d = w_set_proto | (proto_q & ~w_clr_err);
    unr_d   = w_set_unr   | (unr_q   & ~w_clr_err);
  end

  always_ff @(posedge usbClk) begin
    if (!rstSyncToUsbClk_n) begin
      state_q       <= ST_IDLE;
      pid_q         <= '0;
      crc_q         <= CRC16_INIT;
      end_pending_q <= 1'b0;
      append_crc_q  <= 1'b0;
      tx_byte_q     <= '0;
      tx_valid_q    <= 1'b0;
      eop_req_q     <= 1'b0;
      ovf_q         <= 1'b0;
      proto_q       <= 1'b0;
      unr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      crc_q         <= crc_d;
      end_pending_q <= end_pending_d;
      append_crc_q  <= append_crc_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
      eop_req_q     <= eop_req_d;
      ovf_q         <= ovf_d;
      proto_q       <= proto_d;
      unr_q         <= unr_d;
    end
  end

  assign SIEPortTxRdy = rstSyncToUsbClk_n && !w_fifo_full && !end_pending_q;
  assign txByte       = tx_byte_q;
  assign txByteValid  = tx_valid_q;
  assign txEopReq     = eop_req_q;
  assign txBusy       = (state_q != ST_IDLE);
  assign txOverflow   = ovf_q;
  assign txProtoErr   = proto_q;
  assign txUnderrun   = unr_q;

endmodule
`default_nettype wire

// File: doc/sie_port_tx_seq.md
Name: sie_port_tx_seq

Overview:
- Transmit packet sequencer fed directly by the host/slave mux output (SIEPortCtrlInToSIE, SIEPortDataInToSIE, SIEPortWEnToSIE).
- Turns host- or slave-issued port writes into an ordered byte stream for the SIE bit serializer: SYNC, PID, queued payload, optional CRC16, then EOP request.
- Buffers payload bytes in a small FIFO and computes USB CRC16 on the fly.

Parameters:
- FIFO_DEPTH, 4, payload FIFO entries; power of two, at least 2.
- SYNC_BYTE, 8'h80, byte emitted first in every packet (full-speed SYNC, LSB-first).

Ports:
- usbClk  in  1  USB-domain clock.
- rstSyncToUsbClk_n  in  1  Synchronous, active-low reset.
- SIEPortCtrlIn  in  8  Command. [1:0] cmd: 0=CLR_ERR, 1=START, 2=DATA, 3=END. [2]=appendCrc (END only). [7:3] ignored.
- SIEPortDataIn  in  8  PID for START; payload byte for DATA.
- SIEPortWEn  in  1  One-cycle write strobe.
- SIEPortTxRdy  out  1  Can accept a write.
- txByte  out  8  Byte to serializer.
- txByteValid  out  1  txByte valid.
- txByteReady  in  1  Serializer accepts txByte.
- txEopReq  out  1  Request EOP.
- txEopAck  in  1  One-cycle EOP-done pulse.
- txBusy  out  1  State is not IDLE.
- txOverflow  out  1  Sticky: DATA write dropped because FIFO full.
- txProtoErr  out  1  Sticky: illegal command for the current state.
- txUnderrun  out  1  Sticky: serializer ready while in DATA with FIFO empty and no END pending.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; crc=16'hFFFF; endPending=0.
- SIEPortTxRdy = !reset && !fifoFull && !endPending.
- Byte handshake: transfer when txByteValid && txByteReady. After valid rises, txByte stays stable until the transfer completes. txByteValid is registered.
- States:
  - IDLE: START write latches the PID, clears crc to FFFF, goes to SYNC, and sets txByteValid/txByte=SYNC_BYTE on the next cycle (1-cycle latency).
  - SYNC: on transfer, present the PID and go to PID.
  - PID: on transfer, go to DATA. PID is not included in the CRC.
  - DATA: if the FIFO is non-empty, present its head; on transfer, pop it and update crc. If the FIFO is empty and endPending, go to CRC_LO when appendCrc is set, otherwise go to EOP. If the FIFO is empty and no END is pending, txByteValid=0.
  - CRC_LO: present ~crc[7:0]; on transfer, go to CRC_HI.
  - CRC_HI: present ~crc[15:8]; on transfer, go to EOP.
  - EOP: txByteValid=0, txEopReq=1 held until txEopAck, then IDLE with endPending cleared.
- CRC16: reflected, poly 0x8005 (reflected form 0xA001), init FFFF. Update one byte per cycle on each payload transfer.
- DATA writes are accepted in any non-IDLE state before END.
  - A write and a pop in the same cycle are both honoured; the count is unchanged.
  - A write with the FIFO full is dropped and sets txOverflow.
  - DATA in IDLE is dropped and sets txProtoErr.
- END write: sets endPending and latches appendCrc. END in IDLE or a second END is dropped and sets txProtoErr.
- START in any non-IDLE state: dropped, sets txProtoErr, packet continues unaffected.
- CLR_ERR: clears all three sticky flags. If an error event happens in the same cycle, the error wins.
- txUnderrun is set in DATA when txByteReady=1, FIFO empty, and !endPending. The state does not change.
- Reset asserted mid-packet: on the next edge, state IDLE, FIFO flushed, txByteValid=0, txEopReq=0, flags cleared.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Package sie_tx_pkg: command codes CMD_CLR_ERR/START/DATA/END, state enum, CRC16_INIT=16'hFFFF, CRC16_POLY_REFL=16'hA001, and a pure function crc16_byte(crc, byte).
- Sub-module sie_tx_byte_fifo (parameter FIFO_DEPTH): push/pop/full/empty/head.

Test Plan:
- Zero-length packet: START(PID=8'hC3), END(appendCrc=1), txByteReady tied 1 -> stream 80, C3, 00, 00; then txEopReq=1 until the ack pulse; txBusy drops the cycle after the ack.
- Payload with backpressure: START(8'h4B), DATA 01,02,03, END(crc); txByteReady toggled every other cycle -> bytes are never duplicated or lost, txByte is stable while stalled, CRC bytes match the reference model.
- Overflow: START, then 5 DATA writes back-to-back with txByteReady=0 -> first 4 queued, 5th dropped, txOverflow=1, SIEPortTxRdy=0 while full.
- Protocol errors: DATA in IDLE, then a START during an active packet -> txProtoErr=1 and the packet completes normally; a later CLR_ERR returns all flags to 0.
- Underrun and no-CRC end: START, one DATA, then a 3-cycle gap with txByteReady=1 -> txUnderrun=1; then END(appendCrc=0) -> no CRC bytes, straight to EOP.
- Reset mid-packet: assert reset during CRC_LO -> next cycle txByteValid=0, txEopReq=0, state IDLE; a new START is accepted right after reset releases.
